// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Gate-level full adder built from two half adders and an OR gate.
module half_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

module full_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.sum(s1),  .cout(c1), .a(a),  .b(b));
    half_adder u_ha1 (.sum(sum), .cout(c2), .a(s1), .b(cin));

    // The two half-adder carries are never both high, so OR equals XOR here.
    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder plus a carry flop, LSB-first over WIDTH cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   s_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   s_next;

    full_adder u_fa (
        .sum  (fa_sum),
        .cout (fa_cout),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry)
    );

    assign s_next = {fa_sum, s_sr[WIDTH-1:1]};
    assign busy   = (state == S_SHIFT);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: assign the default first so every path drives next_state; no latch.
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SHIFT;
            S_SHIFT: if (cnt == LAST_BIT) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    s_sr  <= s_next;
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    // Result registers update only on the edge that enters DONE.
                    if (cnt == LAST_BIT) begin
                        sum  <= s_next;
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected {cout,sum}, a monitor pops on done.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;
    int n_pushed = 0;
    int n_done = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int last_rand_done = -1;
    bit prev_busy = 1'b0;
    bit prev_done = 1'b0;
    bit rand_phase = 1'b0;
    logic [WIDTH:0] exp_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done and checks handshake timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            cyc++;
            if (busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                check("busy_len", 32'(busy_cnt), 32'(WIDTH));
                busy_cnt = 0;
            end
            if (prev_done) check("done_width", 32'(done), 32'd0);
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
                end
                if (rand_phase) begin
                    if (last_rand_done >= 0)
                        check("done_spacing", 32'(cyc - last_rand_done), 32'(WIDTH + 2));
                    last_rand_done = cyc;
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic push_exp(input logic [WIDTH:0] e);
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Returns at a falling edge with the DUT in IDLE.
    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || done) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", 32'(busy | done), 32'd0);
    endtask

    task automatic run_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic cv, input logic [WIDTH:0] e);
        int k;
        wait_idle();
        a = av;
        b = bv;
        cin = cv;
        start = 1'b1;
        push_exp(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(WIDTH));
    endtask

    initial begin
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic             cv;
        int               k;

        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        #10 rst_n = 1'b1;

        // Load a nonzero result so the abort visibly clears it.
        run_add(8'h5A, 8'h33, 1'b1, 9'h08E);

        // Abort mid-add: outputs clear asynchronously, no done follows.
        wait_idle();
        a = 8'h77;
        b = 8'h11;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);

        run_add(8'h00, 8'h00, 1'b0, 9'h000);
        run_add(8'hFF, 8'h01, 1'b0, 9'h100);
        run_add(8'h5A, 8'h33, 1'b1, 9'h08E);
        run_add(8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // Start while busy is ignored; operand changes after capture are ignored.
        wait_idle();
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        push_exp(9'h030);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("hold_sum_e3",  32'(sum),  32'h0FF);
        check("hold_cout_e3", 32'(cout), 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hold_sum_e7", 32'(sum),  32'h0FF);
        check("busy_e7",     32'(busy), 32'd1);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ignore_done_seen", 32'(done), 32'd1);
        repeat (15) @(negedge clk);

        // Back-to-back random adds with start held high.
        wait_idle();
        rand_phase = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 500; i++) begin
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            cv = 1'($urandom);
            a = av;
            b = bv;
            cin = cv;
            push_exp({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv});
            k = 0;
            while (!busy && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("rand_busy", 32'(busy), 32'd1);
            k = 0;
            while (!done && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("rand_done", 32'(done), 32'd1);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count",  32'(n_done), 32'(n_pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
